msrv32_dmem_bus_master: RTL

Data-memory bus master sitting directly upstream of `msrv32_load_unit`. It accepts one load or store request at a time from the memory stage and runs a single AHB-Lite transfer with wait-state and error handling. It then presents the captured read word and the response status to the load unit. It also drives the pipeline stall while a transfer is outstanding.

---
 rtl/msrv32_pkg.sv | 37 +++
 rtl/msrv32_wait_counter.sv | 36 +++
 rtl/msrv32_dmem_bus_master.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/msrv32_pkg.sv
// ==========================================================================
// msrv32_pkg : shared FSM, AHB and access-size encodings.  Rev 1.0
// ==========================================================================
`default_nettype none

package msrv32_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Encoding 11 behaves exactly like a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'b11) ? SIZE_WORD : size;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
    logic mis;
    case (norm_size(size))
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = lsb[0];
      default:   mis = (lsb != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

`default_nettype wire

// File: rtl/msrv32_wait_counter.sv
// ==========================================================================
// msrv32_wait_counter : saturating counter with clear, enable, terminal count.
// Rev 1.0
// ==========================================================================
`default_nettype none

module msrv32_wait_counter #(
  parameter int MAX_COUNT = 255,
  parameter int WIDTH     = $clog2(MAX_COUNT + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i && (count_q != C_MAX)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign tc_o = (count_q == C_MAX);

endmodule

`default_nettype wire

// File: rtl/msrv32_dmem_bus_master.sv
// ==========================================================================
// msrv32_dmem_bus_master : single-outstanding AHB-Lite data-memory master.
// Rev 1.0
// ==========================================================================
`default_nettype none

module msrv32_dmem_bus_master
  import msrv32_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        req_valid_in,
  output logic        req_ready_out,
  input  logic        req_write_in,
  input  logic [31:0] req_addr_in,
  input  logic [1:0]  req_size_in,
  input  logic [31:0] req_wdata_in,
  output logic [31:0] haddr_out,
  output logic [1:0]  htrans_out,
  output logic        hwrite_out,
  output logic [2:0]  hsize_out,
  output logic [31:0] hwdata_out,
  input  logic [31:0] hrdata_in,
  input  logic        hready_in,
  input  logic        hresp_in,
  output logic [31:0] ms_riscv32_mp_dmdata_out,
  output logic        ahb_resp_out,
  output logic        rsp_valid_out,
  output logic        stall_out
);

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        write_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        accept;
  logic        to_addr;
  logic        wait_en;
  logic        wait_clr;
  logic        wait_tc;

  assign accept  = (state_q == ST_IDLE) && req_valid_in;
  assign to_addr = accept && !is_misaligned(req_size_in, req_addr_in[1:0]);

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_in) begin
          if (is_misaligned(req_size_in, req_addr_in[1:0])) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
          end else begin
            state_d = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        if (hready_in) begin
          state_d = ST_DATA;
        end else if (wait_tc) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
        end
      end
      ST_DATA: begin
        // Load data is captured even on an error beat.
        if (hready_in) begin
          state_d = ST_RESP;
          err_d   = hresp_in;
          if (!write_q) begin
            rdata_d = hrdata_in;
          end
        end else if (wait_tc) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        addr_q  <= req_addr_in;
        size_q  <= norm_size(req_size_in);
        write_q <= req_write_in;
        wdata_q <= req_wdata_in;
      end
    end
  end

  assign wait_clr = to_addr || hready_in;
  assign wait_en  = ((state_q == ST_ADDR) || (state_q == ST_DATA)) && !hready_in;

  msrv32_wait_counter #(
    .MAX_COUNT (TIMEOUT_CYCLES)
  ) u_wait_counter (
    .clk_i (ms_riscv32_mp_clk_in),
    .rst_i (ms_riscv32_mp_rst_in),
    .clr_i (wait_clr),
    .en_i  (wait_en),
    .tc_o  (wait_tc)
  );

  assign req_ready_out            = (state_q == ST_IDLE);
  assign haddr_out                = addr_q;
  assign htrans_out               = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign hwrite_out               = write_q;
  assign hsize_out                = {1'b0, size_q};
  assign hwdata_out               = (state_q == ST_DATA) ? wdata_q : 32'h0;
  assign ms_riscv32_mp_dmdata_out = rdata_q;
  assign ahb_resp_out             = err_q;
  assign rsp_valid_out            = (state_q == ST_RESP);
  assign stall_out                = (req_valid_in && (state_q != ST_IDLE)) ||
                                    (state_q == ST_ADDR) || (state_q == ST_DATA) ||
                                    (state_q == ST_RESP);

endmodule

`default_nettype wire
